// File: rtl/ptw_rr_arbiter_n.sv
// Round-robin arbiter feeding the page-table walker from N requesters.
// One registered output slot; flush discards the held request.
module ptw_rr_arbiter_n #(
  parameter int N_REQ    = 4,
  parameter int REQ_W    = 33,
  parameter int CHOSEN_W = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_flush,
  input  logic [N_REQ-1:0]       io_in_valid,
  output logic [N_REQ-1:0]       io_in_ready,
  input  logic [N_REQ*REQ_W-1:0] io_in_bits,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [REQ_W-1:0]       io_out_bits,
  output logic [CHOSEN_W-1:0]    io_out_chosen
);

  logic                r_out_valid;
  logic [REQ_W-1:0]    r_out_bits;
  logic [CHOSEN_W-1:0] r_out_chosen;
  logic [CHOSEN_W-1:0] r_last_grant;

  logic                w_load_en;
  logic                w_accept;
  logic                w_any;
  logic                w_hi_found;
  logic [CHOSEN_W-1:0] w_hi_idx;
  logic [CHOSEN_W-1:0] w_lo_idx;
  logic [CHOSEN_W-1:0] w_win;
  logic [REQ_W-1:0]    w_bits;

  assign w_load_en = !reset && !io_flush &&
                     (!r_out_valid || io_out_ready);

  // Descending scan leaves the lowest matching index in each slot.
  always_comb begin
    w_any      = 1'b0;
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (io_in_valid[k]) begin
        w_any    = 1'b1;
        w_lo_idx = CHOSEN_W'(k);
        if (CHOSEN_W'(k) > r_last_grant) begin
          w_hi_found = 1'b1;
          w_hi_idx   = CHOSEN_W'(k);
        end
      end
    end
  end

  assign w_win    = w_hi_found ? w_hi_idx : w_lo_idx;
  assign w_accept = w_load_en && w_any;

  always_comb begin
    io_in_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      io_in_ready[k] = w_accept && (w_win == CHOSEN_W'(k));
    end
  end

  always_comb begin
    w_bits = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_win == CHOSEN_W'(k)) begin
        w_bits = io_in_bits[k*REQ_W +: REQ_W];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_bits   <= '0;
      r_out_chosen <= '0;
      r_last_grant <= CHOSEN_W'(N_REQ - 1);
    end else if (io_flush) begin
      r_out_valid  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_bits   <= w_bits;
      r_out_chosen <= w_win;
      r_last_grant <= w_win;
    end else if (r_out_valid && io_out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign io_out_valid  = r_out_valid;
  assign io_out_bits   = r_out_bits;
  assign io_out_chosen = r_out_chosen;

endmodule

// File: tb/tb_ptw_rr_arbiter_n.sv
// Bench for ptw_rr_arbiter_n: directed scenarios plus a randomised run
// checked against a rotating-priority model and an output scoreboard.
module tb_ptw_rr_arbiter_n;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         oready;
  logic [3:0]   valid;
  logic [3:0]   ready;
  logic [32:0]  pay [4];
  logic [131:0] bits;
  logic         ov;
  logic [32:0]  obits;
  logic [1:0]   och;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          ch;
    logic [32:0] b;
  } ent_t;

  ent_t q[$];
  int   m_last;

  always #5 clk = ~clk;

  assign bits = {pay[3], pay[2], pay[1], pay[0]};

  ptw_rr_arbiter_n #(
    .N_REQ(4), .REQ_W(33), .CHOSEN_W(2)
  ) dut (
    .clock(clk),
    .reset(rst),
    .io_flush(flush),
    .io_in_valid(valid),
    .io_in_ready(ready),
    .io_in_bits(bits),
    .io_out_valid(ov),
    .io_out_ready(oready),
    .io_out_bits(obits),
    .io_out_chosen(och)
  );

  function automatic int f_winner(logic [3:0] v, int last);
    for (int i = 1; i <= 4; i++) begin
      int k;
      k = (last + i) % 4;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [3:0] f_ready();
    int w;
    w = f_winner(valid, m_last);
    if (rst || flush || w < 0) return 4'b0000;
    if (q.size() != 0 && !oready) return 4'b0000;
    return 4'b0001 << w;
  endfunction

  task automatic tick(output int acc);
    acc = -1;
    if (!rst && !flush && (q.size() == 0 || oready))
      acc = f_winner(valid, m_last);
    if (rst) begin
      q.delete();
      m_last = 3;
    end else if (flush) begin
      q.delete();
    end else begin
      if (q.size() != 0 && oready) void'(q.pop_front());
      if (acc >= 0) begin
        ent_t e;
        e.ch = acc;
        e.b  = pay[acc];
        q.push_back(e);
        m_last = acc;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_in(logic [3:0] v, logic r, logic f);
    valid  = v;
    oready = r;
    flush  = f;
    #1;
  endtask

  task automatic quiesce();
    int acc;
    set_in(4'b0000, 1'b1, 1'b0);
    tick(acc);
    tick(acc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    oready = 1'b1;
    valid = 4'b1111;
    for (int k = 0; k < 4; k++) pay[k] = 33'({$urandom, $urandom});
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (ov !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", ov);
    end
    checks++;
    if (obits !== 33'd0 || och !== 2'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%0d exp=0/0", obits, och);
    end
    checks++;
    if (ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0000", ready);
    end
    rst = 1'b0;
    q.delete();
    m_last = 3;
    valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    int seq[6] = '{0, 1, 2, 3, 0, 1};
    int acc;
    for (int i = 0; i < 6; i++) begin
      set_in(4'b1111, 1'b1, 1'b0);
      checks++;
      if (ready !== (4'b0001 << seq[i])) begin
        failures++;
        $display("FAIL rr_ready[%0d] got=%b exp=%b", i, ready,
                 4'b0001 << seq[i]);
      end
      checks++;
      if (ov !== (i > 0)) begin
        failures++;
        $display("FAIL rr_valid[%0d] got=%b exp=%b", i, ov, i > 0);
      end
      if (i > 0) begin
        checks++;
        if (q.size() == 0 || och !== 2'(seq[i-1]) || obits !== q[0].b) begin
          failures++;
          $display("FAIL rr_out[%0d] got=%0d/%h exp_ch=%0d", i, och,
                   obits, seq[i-1]);
        end
      end
      tick(acc);
    end
    quiesce();
  endtask

  task automatic test_alternate();
    logic [3:0] exp[3] = '{4'b1000, 4'b0010, 4'b1000};
    int acc;
    set_in(4'b0010, 1'b1, 1'b0);
    tick(acc);
    for (int i = 0; i < 3; i++) begin
      set_in(4'b1010, 1'b1, 1'b0);
      checks++;
      if (ready !== exp[i]) begin
        failures++;
        $display("FAIL alt_ready[%0d] got=%b exp=%b", i, ready, exp[i]);
      end
      checks++;
      if (q.size() == 0 || och !== 2'(q[0].ch) || obits !== q[0].b) begin
        failures++;
        $display("FAIL alt_out[%0d] got=%0d/%h", i, och, obits);
      end
      tick(acc);
    end
    quiesce();
  endtask

  task automatic test_backpressure();
    logic [32:0] b;
    int acc;
    set_in(4'b0100, 1'b0, 1'b0);
    checks++;
    if (ready !== 4'b0100) begin
      failures++;
      $display("FAIL bp_first got=%b exp=0100", ready);
    end
    b = pay[2];
    tick(acc);
    for (int i = 0; i < 5; i++) begin
      set_in(4'b1111, 1'b0, 1'b0);
      checks++;
      if (ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_ready[%0d] got=%b exp=0000", i, ready);
      end
      checks++;
      if (ov !== 1'b1 || och !== 2'd2 || obits !== b) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=%b/%0d/%h exp=1/2/%h", i, ov,
                 och, obits, b);
      end
      tick(acc);
    end
    set_in(4'b1111, 1'b1, 1'b0);
    checks++;
    if (ready !== 4'b1000) begin
      failures++;
      $display("FAIL bp_release got=%b exp=1000", ready);
    end
    tick(acc);
    set_in(4'b0000, 1'b0, 1'b0);
    checks++;
    if (ov !== 1'b1 || och !== 2'd3 || obits !== pay[3]) begin
      failures++;
      $display("FAIL bp_next got=%b/%0d exp=1/3", ov, och);
    end
    quiesce();
  endtask

  task automatic test_flush();
    int acc;
    set_in(4'b0010, 1'b0, 1'b0);
    tick(acc);
    set_in(4'b0001, 1'b1, 1'b1);
    checks++;
    if (ready !== 4'b0000 || ov !== 1'b1 || och !== 2'd1) begin
      failures++;
      $display("FAIL fl_during got=%b/%b/%0d exp=0000/1/1", ready, ov, och);
    end
    tick(acc);
    set_in(4'b0001, 1'b1, 1'b0);
    checks++;
    if (ov !== 1'b0) begin
      failures++;
      $display("FAIL fl_cleared got=%b exp=0", ov);
    end
    checks++;
    if (ready !== 4'b0001) begin
      failures++;
      $display("FAIL fl_after got=%b exp=0001", ready);
    end
    tick(acc);
    set_in(4'b0000, 1'b0, 1'b0);
    checks++;
    if (ov !== 1'b1 || och !== 2'd0 || obits !== pay[0]) begin
      failures++;
      $display("FAIL fl_load got=%b/%0d exp=1/0", ov, och);
    end
    quiesce();
  endtask

  task automatic test_async_reset();
    int acc;
    set_in(4'b0100, 1'b0, 1'b0);
    tick(acc);
    set_in(4'b1111, 1'b0, 1'b0);
    checks++;
    if (ov !== 1'b1) begin
      failures++;
      $display("FAIL ar_pre got=%b exp=1", ov);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ov !== 1'b0 || och !== 2'd0 || obits !== 33'd0) begin
      failures++;
      $display("FAIL ar_immediate got=%b/%0d/%h exp=0/0/0", ov, och, obits);
    end
    checks++;
    if (ready !== 4'b0000) begin
      failures++;
      $display("FAIL ar_ready got=%b exp=0000", ready);
    end
    flush = 1'b1;
    oready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (ov !== 1'b0 || ready !== 4'b0000) begin
      failures++;
      $display("FAIL ar_held got=%b/%b exp=0/0000", ov, ready);
    end
    rst = 1'b0;
    q.delete();
    m_last = 3;
    set_in(4'b1000, 1'b1, 1'b0);
    checks++;
    if (ready !== 4'b1000) begin
      failures++;
      $display("FAIL ar_first got=%b exp=1000", ready);
    end
    tick(acc);
    set_in(4'b0000, 1'b1, 1'b0);
    checks++;
    if (ov !== 1'b1 || och !== 2'd3 || obits !== pay[3]) begin
      failures++;
      $display("FAIL ar_out got=%b/%0d exp=1/3", ov, och);
    end
    quiesce();
  endtask

  task automatic test_random();
    int wcnt[4] = '{0, 0, 0, 0};
    int acc;
    logic [3:0] exp;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (!valid[k] && $urandom_range(0, 2) == 0) begin
          valid[k] = 1'b1;
          pay[k] = 33'({$urandom, $urandom});
        end
      end
      oready = ($urandom_range(0, 3) != 0);
      flush  = ($urandom_range(0, 39) == 0);
      #1;
      exp = f_ready();
      checks++;
      if (ready !== exp) begin
        failures++;
        $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, ready, exp);
      end
      checks++;
      if ($countones(ready) > 1) begin
        failures++;
        $display("FAIL rnd_onehot[%0d] got=%b", c, ready);
      end
      checks++;
      if (ov !== (q.size() != 0)) begin
        failures++;
        $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, ov, q.size() != 0);
      end
      if (ov && oready && q.size() != 0) begin
        checks++;
        if (och !== 2'(q[0].ch) || obits !== q[0].b) begin
          failures++;
          $display("FAIL rnd_sb[%0d] got=%0d/%h exp=%0d/%h", c, och, obits,
                   q[0].ch, q[0].b);
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (ready[k]) begin
          checks++;
          if (wcnt[k] > 3) begin
            failures++;
            $display("FAIL rnd_starve ch=%0d waited=%0d max=3", k, wcnt[k]);
          end
        end
      end
      tick(acc);
      if (acc >= 0) begin
        for (int k = 0; k < 4; k++) begin
          if (k == acc) begin
            valid[k] = 1'b0;
            wcnt[k] = 0;
          end else if (valid[k]) begin
            wcnt[k]++;
          end
        end
      end
    end
    valid = 4'b0000;
    flush = 1'b0;
    quiesce();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_alternate();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
